// File: rtl/db_tile_scheduler.sv
// Double-buffer tile sequencer for a memory_core in mode 3: fills one bank from the input stream
// while the other bank drains into a small skid FIFO that absorbs consumer backpressure.
module db_tile_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_en,
  input  logic [CNT_WIDTH-1:0]  depth,
  input  logic [CNT_WIDTH-1:0]  iter_cnt,
  input  logic [CNT_WIDTH-1:0]  num_tiles,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mem_wen,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  input  logic                  mem_valid_out,
  output logic                  switch_db,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready
);
  localparam int FIFO_D = READ_LAT + 1;
  localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int FCNT_W = $clog2(FIFO_D + 1);
  localparam int CW1    = CNT_WIDTH + 1;
  localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(FIFO_D - 1);
  localparam logic [FCNT_W-1:0] FIFO_FULL  = FCNT_W'(FIFO_D);
  localparam logic [CW1-1:0]    CREDIT_MAX = CW1'(FIFO_D);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_SWITCH, S_STEADY, S_DRAIN, S_FINISH} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  fill_cnt_q, fill_cnt_d;
  logic [CNT_WIDTH-1:0]  drain_cnt_q, drain_cnt_d;
  logic [CNT_WIDTH-1:0]  outstanding_q, outstanding_d;
  logic [CNT_WIDTH-1:0]  tiles_q, tiles_d;
  logic                  zero_done_q, zero_done_d;
  logic [FCNT_W-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_mem [FIFO_D];

  logic                  rd_ok, fin_done, push, pop;
  logic [CW1-1:0]        credit;
  logic [CNT_WIDTH-1:0]  tiles_inc;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == {CNT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Reads in flight plus buffered words may never exceed the FIFO depth.
  assign credit    = {1'b0, outstanding_q} + CW1'(fifo_cnt_q);
  assign tiles_inc = sat_inc(tiles_q);

  assign busy        = (state_q != S_IDLE);
  assign mem_data_in = in_data;
  assign out_valid   = (fifo_cnt_q != '0);
  assign out_data    = out_valid ? fifo_mem[rd_ptr_q] : '0;
  assign push        = mem_valid_out & clk_en & (state_q != S_IDLE);
  assign pop         = out_valid & out_ready & clk_en;

  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    drain_cnt_d   = drain_cnt_q;
    outstanding_d = outstanding_q;
    tiles_d       = tiles_q;
    zero_done_d   = zero_done_q;
    fifo_cnt_d    = fifo_cnt_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    in_ready      = 1'b0;
    rd_ok         = 1'b0;
    switch_db     = 1'b0;
    fin_done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        zero_done_d = 1'b0;
        if (start) begin
          if (depth != '0 && iter_cnt != '0 && num_tiles != '0) begin
            state_d       = S_FILL;
            fill_cnt_d    = '0;
            drain_cnt_d   = '0;
            outstanding_d = '0;
            tiles_d       = '0;
          end else begin
            zero_done_d = 1'b1;
          end
        end
      end
      S_FILL: begin
        in_ready = (fill_cnt_q < depth);
        if (fill_cnt_q == depth) state_d = S_SWITCH;
      end
      S_SWITCH: begin
        switch_db   = clk_en;
        fill_cnt_d  = '0;
        drain_cnt_d = '0;
        tiles_d     = tiles_inc;
        state_d     = (tiles_inc == num_tiles) ? S_DRAIN : S_STEADY;
      end
      S_STEADY: begin
        in_ready = (fill_cnt_q < depth);
        rd_ok    = (drain_cnt_q < iter_cnt) && (credit < CREDIT_MAX);
        if (fill_cnt_q == depth && drain_cnt_q == iter_cnt && outstanding_q == '0)
          state_d = S_SWITCH;
      end
      S_DRAIN: begin
        rd_ok = (drain_cnt_q < iter_cnt) && (credit < CREDIT_MAX);
        if (drain_cnt_q == iter_cnt && outstanding_q == '0) state_d = S_FINISH;
      end
      S_FINISH: begin
        if (fifo_cnt_q == '0) begin
          fin_done = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    mem_wen = in_valid & in_ready & clk_en;
    mem_ren = rd_ok & clk_en;
    done    = clk_en & (fin_done | zero_done_q);

    if (mem_wen) fill_cnt_d  = sat_inc(fill_cnt_q);
    if (mem_ren) drain_cnt_d = sat_inc(drain_cnt_q);
    if (mem_ren && !push)
      outstanding_d = sat_inc(outstanding_q);
    else if (push && !mem_ren && outstanding_q != '0)
      outstanding_d = outstanding_q - 1'b1;

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
    else if (pop && !push) fifo_cnt_d = fifo_cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      fill_cnt_q    <= '0;
      drain_cnt_q   <= '0;
      outstanding_q <= '0;
      tiles_q       <= '0;
      zero_done_q   <= 1'b0;
      fifo_cnt_q    <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else if (clk_en) begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      outstanding_q <= outstanding_d;
      tiles_q       <= tiles_d;
      zero_done_q   <= zero_done_d;
      fifo_cnt_q    <= fifo_cnt_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Payload storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= mem_data_out;
  end

  always_ff @(posedge clk) begin
    if (!reset && push && !pop)
      assert (fifo_cnt_q != FIFO_FULL) else $error("skid fifo overflow");
  end
endmodule

// File: tb/tb_db_tile_scheduler.sv
// Directed bench for db_tile_scheduler with a double-banked READ_LAT=1 memory model and an
// in-order scoreboard of written words against drained words.
module tb_db_tile_scheduler;
  logic        clk = 1'b0;
  logic        reset, clk_en, start, busy, done;
  logic [15:0] depth, iter_cnt, num_tiles;
  logic        in_valid, in_ready, mem_wen, mem_ren, mem_valid_out, switch_db;
  logic        out_valid, out_ready;
  logic [15:0] in_data, mem_data_in, mem_data_out, out_data;

  db_tile_scheduler #(.DATA_WIDTH(16), .CNT_WIDTH(16), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .depth(depth), .iter_cnt(iter_cnt),
    .num_tiles(num_tiles), .start(start), .busy(busy), .done(done), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready), .mem_wen(mem_wen), .mem_data_in(mem_data_in),
    .mem_ren(mem_ren), .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out),
    .switch_db(switch_db), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  // Memory model: writes go to bank wb, reads come from the other bank, swap on switch_db.
  logic [15:0] bank [2][64];
  logic        wb;
  logic [5:0]  waddr, raddr;
  always @(posedge clk) begin
    if (reset) begin
      mem_valid_out <= 1'b0;
      mem_data_out  <= 16'd0;
      wb <= 1'b0; waddr <= 6'd0; raddr <= 6'd0;
    end else if (clk_en) begin
      mem_valid_out <= mem_ren;
      if (mem_ren) begin
        mem_data_out <= bank[wb ? 0 : 1][raddr];
        raddr <= raddr + 6'd1;
      end
      if (mem_wen) begin
        bank[wb ? 1 : 0][waddr] <= mem_data_in;
        waddr <= waddr + 6'd1;
      end
      if (switch_db) begin
        wb <= ~wb; waddr <= 6'd0; raddr <= 6'd0;
      end
    end
  end

  int total = 0, bad = 0;
  int n_wen, n_ren, n_val, n_sw, n_out, n_done, ren_pre, bad_sw, tile_wen, tile_ren, max_infl;
  int cur_depth, cur_iter;
  bit toggle_mode = 1'b0;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit did_wen;
    int infl;
    @(negedge clk);
    did_wen = 1'b0;
    if (clk_en && !reset) begin
      infl = n_ren - n_out;
      if (infl > max_infl) max_infl = infl;
      if (switch_db) begin
        chk("sw_wen", 32'(tile_wen), 32'(cur_depth));
        chk("sw_ren", 32'(tile_ren), (n_sw == 0) ? 32'd0 : 32'(cur_iter));
        chk("sw_outstanding", 32'(n_ren - n_val), 0);
        if (mem_wen || mem_ren) bad_sw++;
        n_sw++; tile_wen = 0; tile_ren = 0;
      end
      if (mem_wen) begin
        did_wen = 1'b1; n_wen++; tile_wen++;
        exp_q.push_back(in_data);
      end
      if (mem_ren) begin
        n_ren++; tile_ren++;
        if (n_sw == 0) ren_pre++;
      end
      if (mem_valid_out) n_val++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_extra", 1, 0);
        else chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        n_out++;
      end
      if (done) n_done++;
    end
    @(posedge clk); #1;
    if (did_wen) in_data = in_data + 16'd1;
    if (toggle_mode) in_valid = ~in_valid;
  endtask

  task automatic start_run(input int d, input int it, input int nt);
    depth = 16'(d); iter_cnt = 16'(it); num_tiles = 16'(nt);
    cur_depth = d; cur_iter = it;
    n_wen = 0; n_ren = 0; n_val = 0; n_sw = 0; n_out = 0; n_done = 0;
    ren_pre = 0; bad_sw = 0; tile_wen = 0; tile_ren = 0; max_infl = 0;
    exp_q.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int tn, input int budget);
    int c = 0;
    while (n_done == 0 && c < budget) begin
      tick();
      c++;
    end
    chk($sformatf("t%0d_timeout", tn), 32'(n_done != 0), 1);
  endtask

  task automatic end_checks(input int tn, input int d, input int it, input int nt);
    tick(); tick();
    chk($sformatf("t%0d_done", tn), 32'(n_done), 1);
    chk($sformatf("t%0d_wen", tn), 32'(n_wen), 32'(d * nt));
    chk($sformatf("t%0d_ren", tn), 32'(n_ren), 32'(it * nt));
    chk($sformatf("t%0d_switch", tn), 32'(n_sw), 32'(nt));
    chk($sformatf("t%0d_out", tn), 32'(n_out), 32'(it * nt));
    chk($sformatf("t%0d_ren_before_sw", tn), 32'(ren_pre), 0);
    chk($sformatf("t%0d_strobe_in_sw", tn), 32'(bad_sw), 0);
    chk($sformatf("t%0d_last_tile_ren", tn), 32'(tile_ren), 32'(it));
    chk($sformatf("t%0d_queue_left", tn), 32'(exp_q.size()), 0);
    chk($sformatf("t%0d_max_inflight_ok", tn), 32'(max_infl <= 2), 1);
    chk($sformatf("t%0d_busy_after", tn), 32'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ov;
    logic [15:0] od;
    int          ren_mark, c;
    reset = 1'b1; clk_en = 1'b1; start = 1'b0; in_valid = 1'b1; in_data = 16'h1000;
    out_ready = 1'b1; depth = 16'd0; iter_cnt = 16'd0; num_tiles = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_wen", 32'(mem_wen), 0);
    chk("rst_ren", 32'(mem_ren), 0);
    chk("rst_switch", 32'(switch_db), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 1: single tile
    start_run(4, 4, 1);
    chk("t1_first_wen_latency", 32'(mem_wen), 1);
    wait_done(1, 200);
    end_checks(1, 4, 4, 1);

    // 2: three tiles of 27
    start_run(27, 27, 3);
    wait_done(2, 2000);
    end_checks(2, 27, 27, 3);

    // 3: consumer stall mid-drain
    start_run(8, 8, 1);
    c = 0;
    while (!(n_sw == 1 && n_out >= 2) && c < 200) begin tick(); c++; end
    chk("t3_reach_drain", 32'(n_sw == 1 && n_out >= 2), 1);
    out_ready = 1'b0;
    repeat (10) tick();
    ren_mark = n_ren;
    repeat (10) tick();
    chk("t3_stall_ren", 32'(n_ren - ren_mark), 0);
    chk("t3_stall_inflight", 32'(n_ren - n_out), 2);
    out_ready = 1'b1;
    wait_done(3, 500);
    end_checks(3, 8, 8, 1);

    // 4: producer valid toggling every cycle
    toggle_mode = 1'b1;
    start_run(8, 8, 3);
    wait_done(4, 1000);
    end_checks(4, 8, 8, 3);
    toggle_mode = 1'b0;
    in_valid = 1'b1;

    // 5: reset in steady state with three words of tile 2 written
    start_run(6, 6, 3);
    c = 0;
    while (!(n_sw == 1 && tile_wen == 3) && c < 200) begin tick(); c++; end
    chk("t5_reach_steady", 32'(n_sw == 1 && tile_wen == 3), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_done", 32'(done), 0);
    chk("t5_in_ready", 32'(in_ready), 0);
    chk("t5_wen", 32'(mem_wen), 0);
    chk("t5_ren", 32'(mem_ren), 0);
    chk("t5_switch", 32'(switch_db), 0);
    chk("t5_out_valid", 32'(out_valid), 0);
    chk("t5_out_data", 32'(out_data), 0);
    reset = 1'b0;
    start_run(4, 4, 2);
    wait_done(5, 300);
    end_checks(5, 4, 4, 2);

    // 6a: zero tile count
    depth = 16'd4; iter_cnt = 16'd4; num_tiles = 16'd0; start = 1'b1;
    @(negedge clk);
    chk("t6_zero_strobes", 32'({mem_wen, mem_ren, switch_db}), 0);
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_zero_done", 32'(done), 1);
    chk("t6_zero_busy", 32'(busy), 0);
    chk("t6_zero_strobes_after", 32'({mem_wen, mem_ren, switch_db}), 0);
    @(posedge clk); #1;
    chk("t6_zero_done_clear", 32'(done), 0);

    // 6b: clock enable low for five cycles mid-run
    start_run(8, 8, 2);
    c = 0;
    while (!(n_sw == 1 && tile_wen >= 2) && c < 200) begin tick(); c++; end
    chk("t6_reach_steady", 32'(n_sw == 1 && tile_wen >= 2), 1);
    clk_en = 1'b0;
    ov = out_valid; od = out_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t6_ce_strobes", 32'({mem_wen, mem_ren, switch_db}), 0);
      chk("t6_ce_busy", 32'(busy), 1);
      chk("t6_ce_out_valid", 32'(out_valid), 32'(ov));
      chk("t6_ce_out_data", 32'(out_data), 32'(od));
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
    wait_done(6, 500);
    end_checks(6, 8, 8, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
